// File: rtl/bsg_test_node_client_echo.sv
// Test-node client: answers cmd=0 packets addressed to it with payload+1 sent to the master,
// quietly absorbs cmd=1 packets, and flags any packet that was routed to the wrong node.
module bsg_test_node_client_echo #(
  parameter ring_width_p = "inv",
  parameter master_id_p  = "inv",
  parameter client_id_p  = "inv",
  parameter els_p        = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i,
  output logic                    error_o,
  output logic [15:0]             count_o
);

  localparam int pw_lp    = ring_width_p - 5;
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int occ_w_lp = $clog2(els_p + 1);

  localparam logic [3:0]          master_id_lp = 4'(master_id_p);
  localparam logic [3:0]          client_id_lp = 4'(client_id_p);
  localparam logic [occ_w_lp-1:0] full_lp      = occ_w_lp'(els_p);

  // Packet fields: {id[3:0], cmd, payload}
  logic [3:0]       in_id;
  logic             in_cmd;
  logic [pw_lp-1:0] in_payload;

  assign in_id      = data_i[ring_width_p-1 -: 4];
  assign in_cmd     = data_i[ring_width_p-5];
  assign in_payload = data_i[ring_width_p-6:0];

  logic [occ_w_lp-1:0] occ_reg;
  logic [occ_w_lp-1:0] occ_next;
  logic [ptr_w_lp-1:0] rptr_reg;
  logic [ptr_w_lp-1:0] rptr_next;
  logic [ptr_w_lp-1:0] wptr_reg;
  logic [ptr_w_lp-1:0] wptr_next;
  logic                error_reg;
  logic                error_next;
  logic [15:0]         count_reg;
  logic [15:0]         count_next;

  logic                    accept;
  logic                    addr_hit;
  logic                    enq;
  logic                    deq;
  logic                    misroute;
  logic [ring_width_p-1:0] resp_data;

  logic [ring_width_p-1:0] mem_r [els_p];

  // ready_o deliberately ignores yumi_i: a full buffer never bypasses.
  assign ready_o  = en_i & ~reset_i & (occ_reg != full_lp);
  assign v_o      = ~reset_i & (occ_reg != '0);
  assign data_o   = mem_r[rptr_reg];

  assign accept   = v_i & ready_o;
  assign addr_hit = (in_id == client_id_lp);
  assign enq      = accept & addr_hit & ~in_cmd;
  assign misroute = accept & ~addr_hit;
  assign deq      = v_o & yumi_i;

  assign resp_data = {master_id_lp, 1'b0, in_payload + 1'b1};

  always_comb begin
    occ_next   = occ_reg;
    rptr_next  = rptr_reg;
    wptr_next  = wptr_reg;
    error_next = error_reg | misroute;
    count_next = count_reg;

    if (enq) begin
      wptr_next = wptr_reg + 1'b1;
    end
    if (deq) begin
      rptr_next = rptr_reg + 1'b1;
      if (count_reg != 16'hFFFF) begin
        count_next = count_reg + 16'd1;
      end
    end

    // Simultaneous push and pop leaves the occupancy where it was.
    if (enq && !deq) begin
      occ_next = occ_reg + 1'b1;
    end else if (!enq && deq) begin
      occ_next = occ_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occ_reg   <= '0;
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      error_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      occ_reg   <= occ_next;
      rptr_reg  <= rptr_next;
      wptr_reg  <= wptr_next;
      error_reg <= error_next;
      count_reg <= count_next;
    end
  end

  // Storage is never reset; an entry is only observable once it has been written.
  for (genvar gi = 0; gi < els_p; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (enq && (wptr_reg == ptr_w_lp'(gi))) begin
        mem_r[gi] <= resp_data;
      end
    end
  end

  assign error_o = error_reg;
  assign count_o = count_reg;

  a_no_yumi_without_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o)
  );

endmodule

// File: tb/tb_bsg_test_node_client_echo.sv
// Bench for the echo client: a fixed vector table for the directed corner cases,
// then randomized traffic compared against a queue-based model of the client's rules.
module tb_bsg_test_node_client_echo;

  localparam int RW = 80;
  localparam int PW = 75;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          en_i = 1'b0;
  logic          v_i = 1'b0;
  logic [RW-1:0] data_i = '0;
  logic          ready_o;
  logic          v_o;
  logic [RW-1:0] data_o;
  logic          yumi_i = 1'b0;
  logic          error_o;
  logic [15:0]   count_o;

  int errors = 0;
  int checks = 0;
  int ncons  = 0;

  always #5 clk = ~clk;

  bsg_test_node_client_echo #(
    .ring_width_p(RW),
    .master_id_p (0),
    .client_id_p (3),
    .els_p       (2)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .en_i   (en_i),
    .v_i    (v_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .v_o    (v_o),
    .data_o (data_o),
    .yumi_i (yumi_i),
    .error_o(error_o),
    .count_o(count_o)
  );

  typedef struct {
    logic          rst, en, v, yumi;
    logic [3:0]    id;
    logic          cmd;
    logic [PW-1:0] pay;
    logic          e_ready, e_v;
    logic [PW-1:0] e_pay;
    logic          e_err;
    logic [15:0]   e_cnt;
  } vec_t;

  vec_t tbl [22];

  // Behavioural model state
  logic [RW-1:0] mq [$];
  logic          m_err = 1'b0;
  logic [15:0]   m_cnt = '0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, en, v, yumi, input logic [3:0] id,
                              input logic cmd, input logic [PW-1:0] pay,
                              input logic er, ev, input logic [PW-1:0] ep,
                              input logic ee, input logic [15:0] ec);
    vec_t t;
    t.rst = rst; t.en = en; t.v = v; t.yumi = yumi; t.id = id; t.cmd = cmd; t.pay = pay;
    t.e_ready = er; t.e_v = ev; t.e_pay = ep; t.e_err = ee; t.e_cnt = ec;
    return t;
  endfunction

  task automatic drive(input logic rst, en, v, yumi, input logic [RW-1:0] d);
    reset_i = rst;
    en_i    = en;
    v_i     = v;
    yumi_i  = yumi;
    data_i  = d;
  endtask

  // One model-checked cycle: compare outputs mid-cycle, then advance the model at the edge.
  task automatic rstep(input logic rst, en, v, yumi, input logic [RW-1:0] d);
    logic acc;
    drive(rst, en, v, yumi, d);
    @(negedge clk);
    chk("m_ready", RW'(ready_o), RW'(!rst && en && mq.size() < 2));
    chk("m_v", RW'(v_o), RW'(!rst && mq.size() > 0));
    chk("m_err", RW'(error_o), RW'(m_err));
    chk("m_cnt", RW'(count_o), RW'(m_cnt));
    if (!rst && mq.size() > 0) chk("m_data", data_o, mq[0]);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_err = 1'b0;
      m_cnt = '0;
    end else begin
      acc = v && en && (mq.size() < 2);
      if (yumi && mq.size() > 0) begin
        ncons++;
        $display("consume %0d data=%h", ncons, mq[0]);
        void'(mq.pop_front());
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (acc) begin
        if (d[RW-1 -: 4] != 4'h3) m_err = 1'b1;
        else if (!d[RW-5]) mq.push_back({4'h0, 1'b0, d[PW-1:0] + 75'd1});
      end
    end
    #1;
  endtask

  initial begin
    logic [PW-1:0] ones;
    logic [95:0]   r;
    logic [PW-1:0] p;
    logic [3:0]    id;
    logic          yu;
    ones = '1;

    //          rst en v  yu id    cmd pay    rdy v  epay err cnt
    tbl[0]  = mk(1, 1, 0, 0, 4'h3, 0, 75'd0,  0, 0, 0,    0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 4'h3, 0, 75'd5,  1, 0, 0,    0, 0);
    tbl[2]  = mk(0, 1, 0, 1, 4'h3, 0, 75'd0,  1, 1, 6,    0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 4'h3, 0, 75'd0,  1, 0, 0,    0, 1);
    tbl[4]  = mk(0, 1, 1, 0, 4'h3, 0, ones,   1, 0, 0,    0, 1);
    tbl[5]  = mk(0, 1, 1, 0, 4'h3, 1, 75'd7,  1, 1, 0,    0, 1);
    tbl[6]  = mk(0, 1, 0, 1, 4'h3, 0, 75'd0,  1, 1, 0,    0, 1);
    tbl[7]  = mk(0, 1, 0, 0, 4'h3, 0, 75'd0,  1, 0, 0,    0, 2);
    tbl[8]  = mk(0, 1, 1, 0, 4'h5, 0, 75'd9,  1, 0, 0,    0, 2);
    tbl[9]  = mk(0, 1, 0, 0, 4'h3, 0, 75'd0,  1, 0, 0,    1, 2);
    tbl[10] = mk(0, 1, 1, 0, 4'h3, 0, 75'd10, 1, 0, 0,    1, 2);
    tbl[11] = mk(0, 1, 1, 0, 4'h3, 0, 75'd20, 1, 1, 11,   1, 2);
    tbl[12] = mk(0, 1, 1, 0, 4'h3, 0, 75'd30, 0, 1, 11,   1, 2);
    tbl[13] = mk(0, 1, 1, 1, 4'h3, 0, 75'd30, 0, 1, 11,   1, 2);
    tbl[14] = mk(0, 1, 1, 0, 4'h3, 0, 75'd30, 1, 1, 21,   1, 3);
    tbl[15] = mk(0, 0, 1, 1, 4'h3, 0, 75'd40, 0, 1, 21,   1, 3);
    tbl[16] = mk(0, 0, 0, 1, 4'h3, 0, 75'd0,  0, 1, 31,   1, 4);
    tbl[17] = mk(0, 0, 0, 0, 4'h3, 0, 75'd0,  0, 0, 0,    1, 5);
    tbl[18] = mk(0, 1, 1, 0, 4'h3, 0, 75'd1,  1, 0, 0,    1, 5);
    tbl[19] = mk(0, 1, 1, 0, 4'h3, 0, 75'd2,  1, 1, 2,    1, 5);
    tbl[20] = mk(1, 1, 0, 1, 4'h3, 0, 75'd0,  0, 0, 0,    1, 5);
    tbl[21] = mk(0, 1, 0, 0, 4'h3, 0, 75'd0,  1, 0, 0,    0, 0);

    // Initial reset so that the table starts from known state
    drive(1, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].v, tbl[i].yumi, {tbl[i].id, tbl[i].cmd, tbl[i].pay});
      @(negedge clk);
      $display("row %0d rdy=%b v=%b data=%h err=%b cnt=%0d", i, ready_o, v_o, data_o, error_o, count_o);
      chk("t_ready", RW'(ready_o), RW'(tbl[i].e_ready));
      chk("t_v", RW'(v_o), RW'(tbl[i].e_v));
      chk("t_err", RW'(error_o), RW'(tbl[i].e_err));
      chk("t_cnt", RW'(count_o), RW'(tbl[i].e_cnt));
      if (tbl[i].e_v) chk("t_data", data_o, {4'h0, 1'b0, tbl[i].e_pay});
      @(posedge clk);
      #1;
    end

    // Misroute followed by ten good packets: error must stay set
    rstep(1, 1, 0, 0, '0);
    rstep(0, 1, 1, 0, {4'h5, 1'b1, 75'd3});
    for (int k = 0; k < 10; k++) begin
      rstep(0, 1, 1, mq.size() > 0, {4'h3, 1'b0, 75'(100 + k)});
    end
    for (int k = 0; k < 3; k++) rstep(0, 1, 0, mq.size() > 0, '0);
    chk("err_sticky", RW'(error_o), RW'(1'b1));

    // Randomized traffic against the model
    rstep(1, 1, 0, 0, '0);
    for (int k = 0; k < 600; k++) begin
      r  = {$urandom, $urandom, $urandom};
      p  = ($urandom_range(0, 15) == 0) ? ones : r[PW-1:0];
      id = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(0, 15)) : 4'h3;
      yu = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      rstep(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 2) != 0), yu,
            {id, ($urandom_range(0, 3) == 0), p});
    end
    while (mq.size() > 0) rstep(0, 0, 0, 1, '0);
    rstep(0, 0, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_test_node_client_echo.md
BSG_TEST_NODE_CLIENT_ECHO -- requirements
Module: bsg_test_node_client_echo

Interface
REQ-001 SHALL have parameter ring_width_p, default "inv", ring packet width in bits; legal values are 8 or more.
REQ-002 SHALL have parameter master_id_p, default "inv", 4-bit node id of the master that receives responses.
REQ-003 SHALL have parameter client_id_p, default "inv", 4-bit node id of this client.
REQ-004 SHALL have parameter els_p, default 2, response buffer depth; legal values are powers of two, 2 or more.
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset_i, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port en_i, input, 1 bit, enables acceptance of input packets.
REQ-008 SHALL have port v_i, input, 1 bit, input packet valid.
REQ-009 SHALL have port data_i, input, ring_width_p bits, input packet.
REQ-010 SHALL have port ready_o, output, 1 bit, client can accept data_i this cycle.
REQ-011 SHALL have port v_o, output, 1 bit, response valid.
REQ-012 SHALL have port data_o, output, ring_width_p bits, response packet.
REQ-013 SHALL have port yumi_i, input, 1 bit, late consume of the response (same cycle as v_o).
REQ-014 SHALL have port error_o, output, 1 bit, sticky flag for a misrouted packet.
REQ-015 SHALL have port count_o, output, 16 bits, number of responses consumed.

Function
REQ-016 SHALL decode input fields as: id = data_i[ring_width_p-1 -: 4]; cmd = data_i[ring_width_p-5]; payload = data_i[ring_width_p-6:0] (width PW = ring_width_p-5).
REQ-017 SHALL drive ready_o = en_i & ~reset_i & (occupancy != els_p); ready_o SHALL NOT depend on yumi_i (no bypass when full).
REQ-018 SHALL accept a packet exactly when v_i & ready_o; data_i is ignored otherwise.
REQ-019 SHALL enqueue, for an accepted packet with id == client_id_p and cmd == 0, the response {master_id_p[3:0], 1'b0, (payload+1) mod 2^PW}; an all-ones payload wraps to 0.
REQ-020 SHALL consume, for an accepted packet with id == client_id_p and cmd == 1, the packet with no response and no count change.
REQ-021 SHALL drop an accepted packet with id != client_id_p, whatever its cmd bit, and set error_o to 1 on the next edge; error_o stays 1 until reset.
REQ-022 SHALL use a circular buffer of els_p entries with read/write pointers that wrap modulo els_p and an occupancy counter of 0..els_p.
REQ-023 SHALL drive v_o = (occupancy != 0), independent of en_i, so the buffer still drains when disabled; data_o = head entry, held stable while v_o=1 and yumi_i=0.
REQ-024 SHALL have a minimum latency of 1 cycle: a packet accepted at edge N into an empty buffer appears on v_o/data_o after edge N.
REQ-025 SHALL, on simultaneous enqueue and dequeue, leave occupancy unchanged and advance both pointers; responses leave in acceptance order.
REQ-026 SHALL increment count_o on each edge with v_o & yumi_i, saturating at 16'hFFFF.
REQ-027 SHALL treat yumi_i=1 while v_o=0 as illegal: a simulation assertion fires, and state is unchanged.
REQ-028 SHALL, when en_i falls while the buffer is non-empty, drop ready_o the same cycle and let buffered responses drain normally.

Reset
REQ-029 SHALL, while reset_i=1 at an edge, clear occupancy, both pointers, error_o and count_o to 0; during reset ready_o=0 and v_o=0.
REQ-030 SHALL discard all buffered responses on reset mid-operation; a yumi_i in a reset cycle has no effect.
REQ-031 SHALL leave buffer storage contents undefined after reset; they are never visible while v_o=0.

Verification (ring_width_p=80, client_id_p=3, master_id_p=0, els_p=2)
REQ-032 SHALL check: en_i=1, a single packet {4'h3, 0, payload 5} with yumi_i=1 on v_o -> v_o=1 one cycle later with data_o={4'h0, 0, 6}, then count_o=1.
REQ-033 SHALL check: 3 back-to-back valid packets with yumi_i=0 -> first two accepted, ready_o=0 on the third cycle, and the third is accepted only after a yumi.
REQ-034 SHALL check: a packet with id 4'h5 -> no response, error_o=1 the next cycle and still 1 after 10 further good packets.
REQ-035 SHALL check: payload all-ones with cmd=0 -> response payload 0; a packet with cmd=1 -> no v_o and count_o unchanged.
REQ-036 SHALL check: full buffer, then reset_i=1 for 1 cycle -> v_o=0, count_o=0, error_o=0, and ready_o=1 the cycle after reset deasserts with en_i=1.
REQ-037 SHALL check: en_i=0 with 2 buffered responses -> ready_o=0, both drain in order under yumi_i, and count_o advances by 2.
